// File: rtl/hdr_input_pkg.sv
// Shared definitions for the button input path: event codes, FSM states and
// the registered event record handed from the FSM to the output slot.
package hdr_input_pkg;

  localparam logic [2:0] EVT_PRESS        = 3'd0;
  localparam logic [2:0] EVT_CLICK        = 3'd1;
  localparam logic [2:0] EVT_LONG         = 3'd2;
  localparam logic [2:0] EVT_REPEAT       = 3'd3;
  localparam logic [2:0] EVT_LONG_RELEASE = 3'd4;

  typedef enum logic [1:0] {
    ST_DISARMED  = 2'd0,
    ST_IDLE      = 2'd1,
    ST_HELD      = 2'd2,
    ST_LONG_HELD = 2'd3
  } btn_state_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] code;
  } evt_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into PRESS/CLICK/LONG/LONG_RELEASE events in a
// single-entry valid/ready slot. Define BUTTON_EVENT_REPEAT_EN for auto-repeat.
module button_event
  import hdr_input_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 8_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_000_000
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       btn,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam int unsigned CNT_MAX = max_u(LONG_CYCLES, REPEAT_CYCLES);
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  btn_state_t       state, state_nxt;
  logic             prev;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise, fall;
  evt_t             emit, pend;

  assign rise = btn & ~prev;
  assign fall = ~btn & prev;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_DISARMED;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      prev  <= btn;
      cnt   <= cnt_nxt;
    end
  end

  // Fall is tested before the thresholds so a release on the threshold cycle
  // reports the shorter event.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_DISARMED: if (!btn) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = ST_LONG_HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (fall) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (cnt == REP_LAST) cnt_nxt = '0;
        else                      cnt_nxt = cnt + 1'b1;
`endif
      end
      default: state_nxt = ST_DISARMED;
    endcase
  end

  always_comb begin
    emit = '0;
    case (state)
      ST_IDLE: if (rise) emit = '{vld: 1'b1, code: EVT_PRESS};
      ST_HELD: begin
        if (fall)                   emit = '{vld: 1'b1, code: EVT_CLICK};
        else if (cnt == LONG_LAST)  emit = '{vld: 1'b1, code: EVT_LONG};
      end
      ST_LONG_HELD: begin
        if (fall) emit = '{vld: 1'b1, code: EVT_LONG_RELEASE};
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (cnt == REP_LAST) emit = '{vld: 1'b1, code: EVT_REPEAT};
`endif
      end
      default: ;
    endcase
  end

  // Events pass through one register stage before the slot, giving a fixed
  // two-cycle latency from the btn change to evt_valid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend      <= '0;
      evt_valid <= 1'b0;
      evt_code  <= EVT_PRESS;
      overrun   <= 1'b0;
    end else begin
      pend <= emit;
      if (pend.vld && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_code  <= pend.code;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (pend.vld && evt_valid && !evt_ready) overrun <= 1'b1;
      else if (overrun_clr)                    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Randomized scoreboard bench for button_event: stimulus pushes the expected
// event sequence, a negedge monitor pops on every accepted transfer.
module tb_button_event;
  import hdr_input_pkg::*;

  localparam int LONG = 100;
  localparam int REP  = 50;

  logic       aclk = 1'b0;
  logic       aresetn, btn, evt_ready, overrun_clr;
  logic       evt_valid, overrun;
  logic [2:0] evt_code;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];
  int         ready_mode  = 0;
  logic       ready_force = 1'b1;
  int         low_run     = 0;
  logic       last_stall  = 1'b0;
  logic [2:0] last_code   = 3'd0;

  button_event #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)) dut (
    .aclk(aclk), .aresetn(aresetn), .btn(btn), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer: random stalls never longer than two cycles in a row.
  always @(posedge aclk) begin
    #1;
    if (ready_mode == 1) begin
      if (low_run >= 2 || $urandom_range(2, 0) != 0) begin
        evt_ready = 1'b1;
        low_run   = 0;
      end else begin
        evt_ready = 1'b0;
        low_run++;
      end
    end else begin
      evt_ready = ready_force;
    end
  end

  // Monitor: every transfer must match the head of the expected queue.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && last_stall) begin
      check("held_valid", evt_valid, 1);
      check("held_code", evt_code, last_code);
    end
    if (aresetn === 1'b1 && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got code %0d expected none", evt_code);
      end else begin
        check("event_code", evt_code, exp_q.pop_front());
      end
    end
    last_stall = (aresetn === 1'b1) && evt_valid && !evt_ready;
    last_code  = evt_code;
  end

  // Reference: a press held for h cycles yields its events by plain arithmetic.
  task automatic push_press(input int h);
    exp_q.push_back(EVT_PRESS);
    if (h <= LONG) exp_q.push_back(EVT_CLICK);
    else begin
      exp_q.push_back(EVT_LONG);
`ifdef BUTTON_EVENT_REPEAT_EN
      for (int t = LONG + REP; t < h; t += REP) exp_q.push_back(EVT_REPEAT);
`endif
      exp_q.push_back(EVT_LONG_RELEASE);
    end
  endtask

  task automatic press(input int h, input int g);
    push_press(h);
    btn = 1'b1;
    repeat (h) @(negedge aclk);
    btn = 1'b0;
    repeat (g) @(negedge aclk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge aclk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic seen;
    int   h;
    aresetn = 1'b0; btn = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_overrun", overrun, 0);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);

    // Short press with latency probe.
    push_press(20);
    btn = 1'b1;
    @(negedge aclk); check("lat1_valid", evt_valid, 0);
    @(negedge aclk); check("lat2_valid", evt_valid, 1); check("lat2_code", evt_code, EVT_PRESS);
    repeat (18) @(negedge aclk);
    btn = 1'b0;
    repeat (10) @(negedge aclk);
    drain("drain_click");

    press(250, 10);      drain("drain_long250");
    press(LONG, 10);     drain("drain_threshold_click");
    press(LONG + 1, 10); drain("drain_threshold_long");

    // Overrun: slot stalls on PRESS, CLICK is dropped.
    ready_force = 1'b0;
    repeat (2) @(negedge aclk);
    exp_q.push_back(EVT_PRESS);
    btn = 1'b1; repeat (10) @(negedge aclk);
    btn = 1'b0; repeat (5) @(negedge aclk);
    check("ovr_valid", evt_valid, 1);
    check("ovr_code", evt_code, EVT_PRESS);
    check("ovr_set", overrun, 1);
    overrun_clr = 1'b1; @(negedge aclk); overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    // A drop in the same cycle as a clear request leaves overrun set.
    overrun_clr = 1'b1; btn = 1'b1;
    @(negedge aclk); check("ovr_pre", overrun, 0);
    @(negedge aclk); check("ovr_set_wins", overrun, 1);
    @(negedge aclk); check("ovr_clr_after", overrun, 0);
    overrun_clr = 1'b0;
    repeat (8) @(negedge aclk);
    btn = 1'b0; repeat (5) @(negedge aclk);
    check("ovr_code_kept", evt_code, EVT_PRESS);
    check("ovr_sticky", overrun, 1);
    ready_force = 1'b1;
    drain("drain_overrun");
    overrun_clr = 1'b1; @(negedge aclk); overrun_clr = 1'b0;
    check("ovr_final_clr", overrun, 0);

    // Reset at hold cycle 50 with the PRESS still parked in the slot.
    ready_force = 1'b0;
    repeat (2) @(negedge aclk);
    btn = 1'b1; repeat (50) @(negedge aclk);
    check("pre_rst_valid", evt_valid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("midrst_valid", evt_valid, 0);
    check("midrst_code", evt_code, 0);
    check("midrst_overrun", overrun, 0);
    ready_force = 1'b1;
    @(negedge aclk);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge aclk); seen |= evt_valid; end
    btn = 1'b0;
    repeat (6) begin @(negedge aclk); seen |= evt_valid; end
    check("disarmed_quiet", seen, 0);
    press(20, 10);
    drain("drain_rearm");

    // Random presses under random backpressure.
    ready_mode = 1;
    for (int i = 0; i < 25; i++) begin
      do begin
        case ($urandom_range(2, 0))
          0:       h = $urandom_range(60, 5);
          1:       h = $urandom_range(LONG + 8, LONG - 4);
          default: h = $urandom_range(270, LONG + 9);
        endcase
      end while (h > LONG && ((h - LONG) % REP) < 5);
      press(h, $urandom_range(40, 5));
    end
    drain("drain_random");
    check("random_no_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
